// File: rtl/key_dev.sv
// key_dev: memory-mapped push-button input peripheral.
// Synchronizes and debounces KEY, exposes KDATA (debounced state, 1 = pressed)
// and KCTRL (bit0 READY, bit2 OVERRUN, bit8 IE) on the shared CPU bus.
//
// Build option: define KEY_DEV_IRQ_EN to implement IE and drive intr = READY & IE.
// Without it IE reads 0, writes to it are ignored and intr is tied 0.
//
// Ports:
//   clk      system clock
//   reset    asynchronous active-high reset
//   ld       CPU load strobe (read)
//   sw       CPU store strobe (write)
//   addrbus  CPU address
//   databus  shared data bus, driven only during a selected read
//   KEY      raw active-low buttons, asynchronous to clk
//   intr     interrupt request
module key_dev #(
  parameter int unsigned      DBITS           = 32,
  parameter logic [DBITS-1:0] KDATAADDR       = 32'hFFFFF080,
  parameter logic [DBITS-1:0] KCTRLADDR       = 32'hFFFFF084,
  parameter int unsigned      KEYBITS         = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 500000,
  parameter int unsigned      CNTBITS         = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ld,
  input  logic               sw,
  input  logic [DBITS-1:0]   addrbus,
  inout  wire  [DBITS-1:0]   databus,
  input  logic [KEYBITS-1:0] KEY,
  output logic               intr
);

  localparam int unsigned      RDY_BIT  = 0;
  localparam int unsigned      OVR_BIT  = 2;
  localparam int unsigned      IE_BIT   = 8;
  localparam logic [CNTBITS-1:0] CNT_LAST = CNTBITS'(DEBOUNCE_CYCLES - 1);

  logic [KEYBITS-1:0] sync1;
  logic [KEYBITS-1:0] sync2;
  logic [KEYBITS-1:0] pressed;
  logic [KEYBITS-1:0] kdata;
  logic [KEYBITS-1:0] upd;
  logic [CNTBITS-1:0] cnt [KEYBITS];

  logic change;
  logic addr_kdata;
  logic addr_kctrl;
  logic rd_kdata;
  logic wr_kctrl;

  logic ready;
  logic ready_n;
  logic ovr;
  logic ovr_n;
  logic ie;

  logic             drive;
  logic [DBITS-1:0] rdata;

  // Two-flop synchronizer; resets to all 1s so keys read as released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= KEY;
      sync2 <= sync1;
    end
  end

  assign pressed = ~sync2;

  // A key updates when it has mismatched kdata for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    upd = '0;
    for (int i = 0; i < int'(KEYBITS); i++) begin
      upd[i] = (pressed[i] != kdata[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign change = |upd;

  // Debounce counters and debounced state; upd implies mismatch, so XOR adopts pressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kdata <= '0;
      for (int i = 0; i < int'(KEYBITS); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      kdata <= kdata ^ upd;
      for (int i = 0; i < int'(KEYBITS); i++) begin
        if ((pressed[i] == kdata[i]) || upd[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNTBITS'(1);
        end
      end
    end
  end

  // Bus decode.
  assign addr_kdata = (addrbus == KDATAADDR);
  assign addr_kctrl = (addrbus == KCTRLADDR);
  assign rd_kdata   = ld && addr_kdata;
  assign wr_kctrl   = sw && addr_kctrl;

  // READY/OVERRUN next state; a new overrun takes priority over a software clear.
  always_comb begin
    ready_n = ready;
    ovr_n   = ovr;
    if (wr_kctrl && !databus[OVR_BIT]) begin
      ovr_n = 1'b0;
    end
    if (change) begin
      ready_n = 1'b1;
      if (ready && !rd_kdata) begin
        ovr_n = 1'b1;
      end
    end else if (rd_kdata) begin
      ready_n = 1'b0;
    end
  end

  // Status register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      ready <= ready_n;
      ovr   <= ovr_n;
    end
  end

`ifdef KEY_DEV_IRQ_EN
  // Interrupt enable and request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie <= 1'b0;
    end else if (wr_kctrl) begin
      ie <= databus[IE_BIT];
    end
  end

  assign intr = ready & ie;
`else
  assign ie   = 1'b0;
  assign intr = 1'b0;
`endif

  // Only a few write-data bits are meaningful; fold the rest away.
  logic unused_wdata;
  assign unused_wdata = ^databus;

  // Combinational read mux; returns pre-edge register contents.
  always_comb begin
    drive = 1'b0;
    rdata = '0;
    if (ld && addr_kdata) begin
      drive = 1'b1;
      rdata = DBITS'(kdata);
    end else if (ld && addr_kctrl) begin
      drive          = 1'b1;
      rdata[RDY_BIT] = ready;
      rdata[OVR_BIT] = ovr;
      rdata[IE_BIT]  = ie;
    end
  end

  assign databus = drive ? rdata : {DBITS{1'bz}};

endmodule

// File: tb/tb_key_dev.sv
// Testbench for key_dev with DEBOUNCE_CYCLES=4. Reads push their expected value
// into a scoreboard queue; a monitor compares databus on every ld cycle.
module tb_key_dev;

  localparam logic [31:0] KDATA = 32'hFFFFF080;
  localparam logic [31:0] KCTRL = 32'hFFFFF084;
  localparam logic [31:0] NOADR = 32'hFFFFF088;
  localparam logic [31:0] PATT  = 32'hA5A5_5A5A;
`ifdef KEY_DEV_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        ld;
  logic        sw;
  logic [31:0] addrbus;
  logic [3:0]  key;
  logic        intr;
  logic        tb_oe;
  logic [31:0] tb_wdata;
  wire  [31:0] databus;

  int n_tests;
  int n_fail;

  logic [31:0] exp_q[$];
  string       name_q[$];

  assign databus = tb_oe ? tb_wdata : 32'hzzzz_zzzz;

  key_dev #(
    .DBITS(32),
    .KDATAADDR(KDATA),
    .KCTRLADDR(KCTRL),
    .KEYBITS(4),
    .DEBOUNCE_CYCLES(4),
    .CNTBITS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ld(ld),
    .sw(sw),
    .addrbus(addrbus),
    .databus(databus),
    .KEY(key),
    .intr(intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every ld cycle presents a bus value to check against the scoreboard.
  always @(negedge clk) begin
    if (ld) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: databus=%h, no expected value queued", databus);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string       n = name_q.pop_front();
        if (databus !== e) begin
          n_fail++;
          $display("FAIL %s: got %h, expected %h", n, databus, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_ld(input logic [31:0] a, input logic [31:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    addrbus = a;
    ld      = 1'b1;
    tick(1);
    ld      = 1'b0;
  endtask

  // Read at an unmapped address while the bench drives the bus: the DUT must stay off it.
  task automatic do_ld_unmapped(input string n);
    tb_wdata = PATT;
    tb_oe    = 1'b1;
    do_ld(NOADR, PATT, n);
    tb_oe    = 1'b0;
  endtask

  task automatic do_sw(input logic [31:0] a, input logic [31:0] d);
    addrbus  = a;
    tb_wdata = d;
    tb_oe    = 1'b1;
    sw       = 1'b1;
    tick(1);
    sw       = 1'b0;
    tb_oe    = 1'b0;
  endtask

  task automatic check_intr(input logic e, input string n);
    n_tests++;
    if (intr !== e) begin
      n_fail++;
      $display("FAIL %s: intr=%b, expected %b", n, intr, e);
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b1;
    ld       = 1'b0;
    sw       = 1'b0;
    addrbus  = '0;
    key      = 4'hF;
    tb_oe    = 1'b0;
    tb_wdata = '0;
    tick(2);
    reset = 1'b0;
    tick(1);

    // Reset state and bus release.
    do_ld(KDATA, 32'h0, "reset_kdata");
    do_ld(KCTRL, 32'h0, "reset_kctrl");
    check_intr(1'b0, "reset_intr");
    tb_wdata = PATT;
    tb_oe    = 1'b1;
    #1;
    n_tests++;
    if (databus !== PATT) begin
      n_fail++;
      $display("FAIL idle_release: databus=%h, expected bench pattern %h", databus, PATT);
    end
    tb_oe = 1'b0;
    do_ld_unmapped("unmapped_read_release");

    // Press key 0: KDATA/READY update exactly 6 cycles after the edge.
    key = 4'b1110;
    tick(4);
    do_ld(KCTRL, 32'h0, "latency_c5");
    do_ld(KCTRL, 32'h0, "latency_c6_pre");
    do_ld(KCTRL, 32'h1, "press0_ready");
    do_ld(KDATA, 32'h1, "press0_kdata");
    do_ld(KCTRL, 32'h0, "press0_ready_consumed");

    // Release key 0.
    key = 4'b1111;
    tick(6);
    do_ld(KCTRL, 32'h1, "release0_ready");
    do_ld(KDATA, 32'h0, "release0_kdata");
    do_ld(KCTRL, 32'h0, "release0_consumed");

    // Three-cycle glitch on key 1 is rejected.
    key = 4'b1101;
    tick(3);
    key = 4'b1111;
    tick(8);
    do_ld(KCTRL, 32'h0, "glitch_ready");
    do_ld(KDATA, 32'h0, "glitch_kdata");

    // Two unread changes produce an overrun.
    key = 4'b1110;
    tick(6);
    key = 4'b1010;
    tick(6);
    do_ld(KCTRL, 32'h5, "overrun_set");
    do_sw(KCTRL, 32'h4);
    do_ld(KCTRL, 32'h5, "overrun_write1_noeffect");
    do_sw(KDATA, 32'h0);
    do_sw(NOADR, 32'h0);
    do_ld(KCTRL, 32'h5, "ignored_writes");
    do_sw(KCTRL, 32'h0);
    do_ld(KCTRL, 32'h1, "overrun_cleared");
    do_ld(KDATA, 32'h5, "two_keys_kdata");
    do_ld(KCTRL, 32'h0, "two_keys_consumed");

    // Read coincident with a debounced change: READY stays 1, no overrun.
    key = 4'b1110;
    tick(5);
    do_ld(KDATA, 32'h5, "coincident_read_old");
    do_ld(KCTRL, 32'h1, "coincident_ready_kept");

    // Clear of OVERRUN in the same cycle a new overrun occurs: set wins.
    key = 4'b1111;
    tick(5);
    do_sw(KCTRL, 32'h0);
    do_ld(KCTRL, 32'h5, "overrun_set_wins");
    do_ld(KDATA, 32'h0, "set_wins_kdata");
    do_ld(KCTRL, 32'h4, "set_wins_overrun_kept");
    do_sw(KCTRL, 32'h0);
    do_ld(KCTRL, 32'h0, "set_wins_cleared");

    // Interrupt enable.
    do_sw(KCTRL, 32'h100);
    do_ld(KCTRL, IRQ ? 32'h100 : 32'h0, "ie_readback");
    check_intr(1'b0, "intr_idle_ie");
    key = 4'b1110;
    tick(6);
    check_intr(IRQ, "intr_ready");
    do_ld(KCTRL, IRQ ? 32'h101 : 32'h1, "ie_ready_kctrl");
    do_ld(KDATA, 32'h1, "ie_kdata");
    check_intr(1'b0, "intr_cleared");
    do_ld(KCTRL, IRQ ? 32'h100 : 32'h0, "ie_after_read");

    // Reset in the middle of a debounce on key 3 (count reaches 3).
    key = 4'b0110;
    tick(5);
    reset = 1'b1;
    #1;
    check_intr(1'b0, "midreset_intr");
    do_ld(KDATA, 32'h0, "midreset_kdata");
    reset = 1'b0;
    tick(5);
    do_ld(KDATA, 32'h0, "redebounce_c6_pre");
    do_ld(KCTRL, 32'h1, "redebounce_ready");
    do_ld(KDATA, 32'h9, "redebounce_kdata");

    tick(2);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
